// File: rtl/keypad_scan_ctl_if.sv
// Keypad scan controller bus: matrix row/column lines plus the debounced
// key report. The controller side uses "master", the board/user side "slave".
`timescale 1ns/1ps
interface keypad_scan_ctl_if;
   logic [3:0] row_n;      // keypad rows, active-low, pulled up off-chip
   logic [3:0] col_n;      // column drive, active-low, one-hot-low
   logic [3:0] key_code;   // last accepted key, col*4 + row
   logic       key_valid;  // one-cycle strobe on a new accept
   logic       key_down;   // debounced hold level
   logic       multi;      // last frame saw two or more pressed positions

   modport master (
      input  row_n,
      output col_n,
      output key_code,
      output key_valid,
      output key_down,
      output multi
   );

   modport slave (
      output row_n,
      input  col_n,
      input  key_code,
      input  key_valid,
      input  key_down,
      input  multi
   );
endinterface

// File: rtl/keypad_scan_ctl.sv
// 4x4 matrix keypad scanner: drives one column low per dwell period, collects
// a full 16-position frame, and debounces whole frames into single key reports.
// Frame classification happens on the last column's tick edge, so the
// registered outputs change at the start of the frame-eval cycle.
`timescale 1ns/1ps
module keypad_scan_ctl #(
   parameter int unsigned SCAN_CYCLES     = 100000,
   parameter int unsigned DEBOUNCE_FRAMES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   keypad_scan_ctl_if.master kp
);

   localparam int unsigned CW = $clog2(SCAN_CYCLES);
   localparam int unsigned FW = $clog2(DEBOUNCE_FRAMES + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAND    = 2'd1,
      ST_PRESSED = 2'd2,
      ST_REL     = 2'd3
   } state_t;

   // Number of pressed positions in a frame.
   function automatic logic [4:0] f_popcount(input logic [15:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

   // Position of the lowest pressed bit; only meaningful for single presses.
   function automatic logic [3:0] f_low_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [CW-1:0] r_dwell;
   logic [1:0]    r_col_idx;
   logic [3:0]    r_col_n;
   logic [11:0]   r_acc;
   state_t        r_state;
   logic [FW-1:0] r_cnt;
   logic [3:0]    r_cand;
   logic [3:0]    r_key_code;
   logic          r_key_valid;
   logic          r_key_down;
   logic          r_multi;

   logic          w_tick;
   logic          w_frame_done;
   logic [3:0]    w_row_act;
   logic [1:0]    w_col_idx_nxt;
   logic [15:0]   w_frame;
   logic [4:0]    w_pop;
   logic          w_single;
   logic          w_multi;
   logic [3:0]    w_idx;
   logic          w_held;
   logic [FW-1:0] w_cnt_inc;

   state_t        w_state_nxt;
   logic [FW-1:0] w_cnt_nxt;
   logic [3:0]    w_cand_nxt;
   logic          w_accept;
   logic          w_release;

   logic [3:0]    w_key_code_nxt;
   logic          w_key_valid_nxt;
   logic          w_key_down_nxt;
   logic          w_multi_nxt;

   assign w_tick        = (r_dwell == CW'(SCAN_CYCLES - 1));
   assign w_frame_done  = w_tick && (r_col_idx == 2'd3);
   assign w_row_act     = ~r_sync2;
   assign w_col_idx_nxt = r_col_idx + 2'd1;
   // Column 3 is taken live from the synchronizer on the completing tick.
   assign w_frame       = {w_row_act, r_acc};
   assign w_pop         = f_popcount(w_frame);
   assign w_single      = (w_pop == 5'd1);
   assign w_multi       = (w_pop >= 5'd2);
   assign w_idx         = f_low_idx(w_frame);
   assign w_held        = w_frame[r_key_code];
   assign w_cnt_inc     = r_cnt + FW'(1);

   // Two-flop synchronizer for the asynchronous row inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 4'b1111;
         r_sync2 <= 4'b1111;
      end else begin
         r_sync1 <= kp.row_n;
         r_sync2 <= r_sync1;
      end
   end

   // Dwell counter and column rotation; a column advances on each tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dwell   <= '0;
         r_col_idx <= 2'd0;
         r_col_n   <= 4'b1110;
      end else if (w_tick) begin
         r_dwell   <= '0;
         r_col_idx <= w_col_idx_nxt;
         r_col_n   <= ~(4'b0001 << w_col_idx_nxt);
      end else begin
         r_dwell   <= r_dwell + CW'(1);
      end
   end

   // Frame accumulator: columns 0..2 are stored, column 3 completes and clears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= 12'd0;
      end else if (w_tick) begin
         case (r_col_idx)
            2'd0:    r_acc[3:0]  <= w_row_act;
            2'd1:    r_acc[7:4]  <= w_row_act;
            2'd2:    r_acc[11:8] <= w_row_act;
            default: r_acc       <= 12'd0;
         endcase
      end else begin
         r_acc <= r_acc;
      end
   end

   // Debounce FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_cand  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
      end
   end

   // Debounce FSM next-state logic; only completed frames move it.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      if (w_frame_done) begin
         case (r_state)
            ST_IDLE: begin
               if (w_single) begin
                  w_cand_nxt = w_idx;
                  if (DEBOUNCE_FRAMES == 1) begin
                     w_state_nxt = ST_PRESSED;
                     w_cnt_nxt   = '0;
                     w_accept    = 1'b1;
                  end else begin
                     w_state_nxt = ST_CAND;
                     w_cnt_nxt   = FW'(1);
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_CAND: begin
               if (w_single && (w_idx == r_cand)) begin
                  if (w_cnt_inc == FW'(DEBOUNCE_FRAMES)) begin
                     w_state_nxt = ST_PRESSED;
                     w_cnt_nxt   = '0;
                     w_accept    = 1'b1;
                  end else begin
                     w_cnt_nxt   = w_cnt_inc;
                  end
               end else if (w_single) begin
                  w_cand_nxt = w_idx;
                  w_cnt_nxt  = FW'(1);
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            ST_PRESSED: begin
               // A held key masks every other position: no rollover.
               if (w_held) begin
                  w_state_nxt = ST_PRESSED;
               end else if (DEBOUNCE_FRAMES == 1) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
                  w_release   = 1'b1;
               end else begin
                  w_state_nxt = ST_REL;
                  w_cnt_nxt   = FW'(1);
               end
            end
            ST_REL: begin
               if (!w_held) begin
                  if (w_cnt_inc == FW'(DEBOUNCE_FRAMES)) begin
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                     w_release   = 1'b1;
                  end else begin
                     w_cnt_nxt   = w_cnt_inc;
                  end
               end else begin
                  w_state_nxt = ST_PRESSED;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Output next values: strobe on accept, hold level, multi per frame.
   always_comb begin
      w_key_code_nxt  = r_key_code;
      w_key_valid_nxt = 1'b0;
      w_key_down_nxt  = r_key_down;
      w_multi_nxt     = r_multi;
      if (w_frame_done) begin
         w_multi_nxt = w_multi;
         if (w_accept) begin
            w_key_code_nxt  = w_cand_nxt;
            w_key_valid_nxt = 1'b1;
            w_key_down_nxt  = 1'b1;
         end else if (w_release) begin
            w_key_down_nxt  = 1'b0;
         end else begin
            w_key_down_nxt  = r_key_down;
         end
      end else begin
         w_key_valid_nxt = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_down  <= 1'b0;
         r_multi     <= 1'b0;
      end else begin
         r_key_code  <= w_key_code_nxt;
         r_key_valid <= w_key_valid_nxt;
         r_key_down  <= w_key_down_nxt;
         r_multi     <= w_multi_nxt;
      end
   end

   assign kp.col_n     = r_col_n;
   assign kp.key_code  = r_key_code;
   assign kp.key_valid = r_key_valid;
   assign kp.key_down  = r_key_down;
   assign kp.multi     = r_multi;

endmodule

// File: tb/tb_keypad_scan_ctl.sv
// Bench for keypad_scan_ctl: a frame-level keypad model drives the rows, a
// debounce reference model pushes one expectation per frame, and a monitor
// compares outputs every cycle against the latest popped expectation.
`timescale 1ns/1ps
module tb_keypad_scan_ctl;

   localparam int SC    = 8;
   localparam int DF    = 3;
   localparam int FRAME = 4 * SC;

   typedef struct {
      int         frame;
      bit         valid;
      logic [3:0] code;
      bit         down;
      bit         multi;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] keys = 16'd0;
   logic [3:0]  row_drv;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   // reference model state
   bit         m_down;
   logic [3:0] m_code;
   int         m_run_len;
   logic [3:0] m_run_key;
   int         m_absent;
   int         frame_no;

   always #5 clk = ~clk;

   keypad_scan_ctl_if kp_if();

   keypad_scan_ctl #(.SCAN_CYCLES(SC), .DEBOUNCE_FRAMES(DF)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .kp   (kp_if)
   );

   // Physical keypad: a pressed (c,r) pulls row r low while column c is driven.
   always_comb begin
      row_drv = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[c*4 + r] && !kp_if.col_n[c]) row_drv[r] = 1'b0;
         end
      end
   end
   assign kp_if.row_n = row_drv;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_down    = 1'b0;
      m_code    = 4'd0;
      m_run_len = 0;
      m_run_key = 4'd0;
      m_absent  = 0;
      frame_no  = 0;
   endtask

   // Present one frame of key state and record what the debouncer must report.
   task automatic run_frame(input logic [15:0] mask);
      exp_t       e;
      int         n;
      logic [3:0] k;
      keys = mask;
      n = $countones(mask);
      k = 4'd0;
      for (int i = 0; i < 16; i++) if (mask[i]) k = 4'(i);
      e.valid = 1'b0;
      if (!m_down) begin
         if (n == 1) begin
            if (m_run_len > 0 && m_run_key == k) m_run_len++;
            else m_run_len = 1;
            m_run_key = k;
            if (m_run_len == DF) begin
               m_down = 1'b1; m_code = k; e.valid = 1'b1;
               m_run_len = 0; m_absent = 0;
            end
         end else begin
            m_run_len = 0;
         end
      end else begin
         if (mask[m_code]) m_absent = 0;
         else begin
            m_absent++;
            if (m_absent == DF) begin
               m_down = 1'b0; m_absent = 0; m_run_len = 0;
            end
         end
      end
      e.frame = frame_no;
      e.code  = m_code;
      e.down  = m_down;
      e.multi = (n >= 2);
      exp_q.push_back(e);
      frame_no++;
      repeat (FRAME) @(negedge clk);
   endtask

   task automatic run_frames(input logic [15:0] mask, input int count);
      for (int i = 0; i < count; i++) run_frame(mask);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_col_n"}, int'(kp_if.col_n), 14);
      chk({tag, "_key_code"}, int'(kp_if.key_code), 0);
      chk({tag, "_key_valid"}, int'(kp_if.key_valid), 0);
      chk({tag, "_key_down"}, int'(kp_if.key_down), 0);
      chk({tag, "_multi"}, int'(kp_if.multi), 0);
   endtask

   // Monitor: scan sequence every cycle, scoreboard pop on each eval cycle.
   initial begin
      int         cyc;
      bit         l_down;
      bit         l_multi;
      logic [3:0] l_code;
      logic [3:0] exp_col;
      exp_t       e;
      cyc = 0; l_down = 1'b0; l_multi = 1'b0; l_code = 4'd0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            cyc = 0; l_down = 1'b0; l_multi = 1'b0; l_code = 4'd0;
            continue;
         end
         cyc++;
         exp_col = 4'b1111;
         exp_col[(cyc / SC) % 4] = 1'b0;
         chk("col_n", int'(kp_if.col_n), int'(exp_col));
         if (cyc % FRAME == 0) begin
            if (exp_q.size() == 0) begin
               chk("expectation_available", 0, 1);
            end else begin
               e = exp_q.pop_front();
               chk("eval_frame_index", cyc / FRAME - 1, e.frame);
               chk("eval_key_valid", int'(kp_if.key_valid), int'(e.valid));
               chk("eval_key_down", int'(kp_if.key_down), int'(e.down));
               chk("eval_multi", int'(kp_if.multi), int'(e.multi));
               chk("eval_key_code", int'(kp_if.key_code), int'(e.code));
               l_down = e.down; l_multi = e.multi; l_code = e.code;
            end
         end else begin
            chk("key_valid_outside_eval", int'(kp_if.key_valid), 0);
            chk("key_down_hold", int'(kp_if.key_down), int'(l_down));
            chk("multi_hold", int'(kp_if.multi), int'(l_multi));
            chk("key_code_hold", int'(kp_if.key_code), int'(l_code));
         end
      end
   end

   // Watchdog: the stimulus is bounded, so reaching this means a hang.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus.
   initial begin
      logic [15:0] prev;
      logic [15:0] m;
      int          sel;
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      run_frames(16'h0000, 10);               // idle scan
      run_frames(16'h0200, 6);                // press code 9 and hold
      run_frames(16'h0000, 1);                // bounce release
      run_frames(16'h0200, 3);                // re-press, no new strobe
      run_frames(16'h0000, 4);                // real release
      run_frames(16'h0008, 2);                // glitch on code 3
      run_frames(16'h1000, 5);                // code 12 accepted
      run_frames(16'h0000, 4);
      run_frames(16'h0420, 4);                // two keys from idle
      run_frames(16'h0000, 2);
      run_frames(16'h0020, 4);                // code 5 accepted
      run_frames(16'h0420, 3);                // add a second key while held
      run_frames(16'h0000, 4);

      prev = 16'h0000;
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0, 1, 2: m = prev;
            3:       m = 16'h0000;
            4:       m = 16'h0001 << $urandom_range(0, 15);
            default: m = (16'h0001 << $urandom_range(0, 15)) |
                         (16'h0001 << $urandom_range(0, 15));
         endcase
         run_frame(m);
         prev = m;
      end
      run_frames(16'h0000, 4);

      // Reset in the middle of a candidate run (two agreeing frames seen).
      run_frames(16'h0080, 2);
      keys = 16'h0080;
      repeat (12) @(negedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      exp_q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_frames(16'h0080, 4);                // needs three full frames again
      run_frames(16'h0000, 4);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
